// File: rtl/exception_writeback.sv
// Carries execute-stage exception codes through X/M and M/W, merges multdiv completions into the
// single writeback port, and tracks a sticky status copy plus a saturating exception counter.
module exception_writeback #(
  parameter int unsigned RSTATUS_REG = 30,
  parameter int unsigned MULT_CODE   = 4,
  parameter int unsigned DIV_CODE    = 5,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             x_valid,
  input  logic             x_we,
  input  logic [4:0]       x_rd,
  input  logic [31:0]      x_result,
  input  logic [31:0]      x_exception,
  input  logic             x_overflow,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic [4:0]       md_rd,
  input  logic             md_ready,
  input  logic             md_error,
  input  logic [31:0]      md_result,
  output logic             w_we,
  output logic [4:0]       w_rd,
  output logic [31:0]      w_data,
  output logic             md_busy,
  output logic             stall_req,
  output logic [31:0]      rstatus_sticky,
  output logic [CNT_W-1:0] exc_count
);

  localparam logic [4:0]  RsReg    = 5'(RSTATUS_REG);
  localparam logic [31:0] MultCode = 32'(MULT_CODE);
  localparam logic [31:0] DivCode  = 32'(DIV_CODE);

  typedef enum logic [1:0] {StIdle, StBusy, StCommit} state_e;

  state_e      state_q;
  logic [4:0]  md_rd_q;
  logic [31:0] md_code_q;
  logic        pend_q;

  logic        xm_we_q, xm_exc_q;
  logic [4:0]  xm_rd_q;
  logic [31:0] xm_data_q;
  logic        mw_we_q, mw_exc_q;
  logic [4:0]  mw_rd_q;
  logic [31:0] mw_data_q;

  logic        x_exc;
  logic        adv;
  logic        commit_enter;
  logic        w_load;
  logic        nw_we, nw_exc;
  logic [4:0]  nw_rd;
  logic [31:0] nw_data;

  assign x_exc        = x_valid & x_overflow & (x_exception != 32'd0);
  // COMMIT borrows the write port, so the pipeline freezes exactly as under an external stall.
  assign adv          = ~stall & (state_q != StCommit);
  assign commit_enter = (state_q == StBusy) & md_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      md_busy   <= 1'b0;
      stall_req <= 1'b0;
      md_rd_q   <= 5'd0;
      md_code_q <= 32'd0;
      pend_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (md_start) begin
            state_q   <= StBusy;
            md_busy   <= 1'b1;
            md_rd_q   <= md_rd;
            md_code_q <= md_is_div ? DivCode : MultCode;
          end
        end
        StBusy: begin
          if (md_ready) begin
            state_q   <= StCommit;
            stall_req <= 1'b1;
            // Only an M/W entry loaded on this edge is still unseen at writeback.
            pend_q    <= adv;
          end
        end
        StCommit: begin
          state_q   <= StIdle;
          md_busy   <= 1'b0;
          stall_req <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          md_busy   <= 1'b0;
          stall_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xm_we_q   <= 1'b0;
      xm_exc_q  <= 1'b0;
      xm_rd_q   <= 5'd0;
      xm_data_q <= 32'd0;
      mw_we_q   <= 1'b0;
      mw_exc_q  <= 1'b0;
      mw_rd_q   <= 5'd0;
      mw_data_q <= 32'd0;
    end else begin
      if (flush) begin
        xm_we_q   <= 1'b0;
        xm_exc_q  <= 1'b0;
        xm_rd_q   <= 5'd0;
        xm_data_q <= 32'd0;
      end else if (adv) begin
        xm_we_q   <= x_exc | (x_valid & x_we & (x_rd != 5'd0));
        xm_exc_q  <= x_exc;
        xm_rd_q   <= x_exc ? RsReg : x_rd;
        xm_data_q <= x_exc ? x_exception : x_result;
      end
      if (adv) begin
        mw_we_q   <= xm_we_q;
        mw_exc_q  <= xm_exc_q;
        mw_rd_q   <= xm_rd_q;
        mw_data_q <= xm_data_q;
      end
    end
  end

  // Next writeback value; w_load marks edges that present a new write rather than a held one.
  always_comb begin
    w_load  = 1'b0;
    nw_we   = 1'b0;
    nw_exc  = 1'b0;
    nw_rd   = 5'd0;
    nw_data = 32'd0;
    if (commit_enter) begin
      w_load = 1'b1;
      if (md_error) begin
        nw_we   = 1'b1;
        nw_exc  = 1'b1;
        nw_rd   = RsReg;
        nw_data = md_code_q;
      end else begin
        nw_we   = (md_rd_q != 5'd0);
        nw_rd   = md_rd_q;
        nw_data = md_result;
      end
    end else if (state_q == StCommit) begin
      w_load  = 1'b1;
      nw_we   = mw_we_q & pend_q;
      nw_exc  = mw_exc_q & pend_q;
      nw_rd   = mw_rd_q;
      nw_data = mw_data_q;
    end else if (adv) begin
      w_load  = 1'b1;
      nw_we   = xm_we_q;
      nw_exc  = xm_exc_q;
      nw_rd   = xm_rd_q;
      nw_data = xm_data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_we           <= 1'b0;
      w_rd           <= 5'd0;
      w_data         <= 32'd0;
      rstatus_sticky <= 32'd0;
      exc_count      <= '0;
    end else if (w_load) begin
      w_we   <= nw_we;
      w_rd   <= nw_rd;
      w_data <= nw_data;
      if (nw_exc) begin
        rstatus_sticky <= nw_data;
        if (exc_count != {CNT_W{1'b1}}) begin
          exc_count <= exc_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule
